// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback and drives every datapath enable and mux select.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned SEL_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'h20);
  localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'h22);
  localparam logic [OP_W-1:0] FN_AND = OP_W'(6'h24);
  localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'h25);
  localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'h2A);

  localparam logic [SEL_W-1:0] ALU_AND = SEL_W'(0);
  localparam logic [SEL_W-1:0] ALU_OR  = SEL_W'(1);
  localparam logic [SEL_W-1:0] ALU_ADD = SEL_W'(2);
  localparam logic [SEL_W-1:0] ALU_SUB = SEL_W'(6);
  localparam logic [SEL_W-1:0] ALU_SLT = SEL_W'(7);

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC,
    S_RTWB, S_BEQ, S_ADDIEXEC, S_ADDIWB, S_JUMP, S_ILLEGAL
  } state_t;

  state_t state, state_nxt;
  logic   funct_ok;

  // State register; reset drops straight back to FETCH regardless of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    funct_ok   = 1'b1;
    alu_sel    = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // Gated by rst_n so no load can slip through while reset is held.
        ir_write  = mem_ready & rst_n;
        pc_en     = mem_ready & rst_n;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTEXEC;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_ADDI:      state_nxt = S_ADDIEXEC;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_RTEXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: funct_ok = 1'b0;
        endcase
        state_nxt = funct_ok ? S_RTWB : S_ILLEGAL;
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = alu_zero;
        state_nxt = S_FETCH;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = PCSRC_JUMP;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, hand corner cases and
// random instruction streams checked against a per-instruction cycle model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] alu_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic rdy;
    logic zero;
    logic fetch;
    out_t exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         cycles;
    int         sel_at2;
    int         n_rw;
    int         n_mw;
    int         n_ill;
    int         n_pcen;
  } vec_t;

  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, illegal;

  int n_vec = 0;
  int n_bad = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .alu_sel(alu_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal)
  );

  out_t obs;
  assign obs = {alu_sel, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: expected per-cycle outputs ----------
  step_t q[$];
  logic [5:0] cur_op, cur_fn;

  function automatic out_t idle_out();
    out_t o = '0;
    o.alu_sel = 3'd2;
    return o;
  endfunction

  function automatic out_t fetch_out(input logic done);
    out_t o = idle_out();
    o.mem_read  = 1'b1;
    o.alu_src_b = 2'b01;
    o.ir_write  = done;
    o.pc_en     = done;
    return o;
  endfunction

  task automatic push(input logic rdy, input logic zero, input logic f, input out_t e);
    step_t s;
    s.rdy = rdy; s.zero = zero; s.fetch = f; s.exp = e;
    q.push_back(s);
  endtask

  // A cycle whose outcome ignores mem_ready/alu_zero: drive them randomly.
  task automatic push_free(input out_t e);
    push(1'($urandom), 1'($urandom), 1'b0, e);
  endtask

  task automatic push_wait(input out_t ow, input out_t od, input int stalls, input logic f);
    for (int i = 0; i < stalls; i++) push(1'b0, 1'($urandom), f, ow);
    push(1'b1, 1'($urandom), f, od);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int fstall, input int mstall);
    out_t o;
    logic z;
    logic ok;
    logic [2:0] sel;
    cur_op = op;
    cur_fn = fn;
    push_wait(fetch_out(1'b0), fetch_out(1'b1), fstall, 1'b1);
    o = idle_out(); o.alu_src_b = 2'b11;
    push_free(o);
    case (op)
      6'h23, 6'h2B: begin
        o = idle_out(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        push_free(o);
        if (op == 6'h23) begin
          o = idle_out(); o.mem_read = 1'b1; o.iord = 1'b1;
          push_wait(o, o, mstall, 1'b0);
          o = idle_out(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          push_free(o);
        end else begin
          o = idle_out(); o.mem_write = 1'b1; o.iord = 1'b1;
          push_wait(o, o, mstall, 1'b0);
        end
      end
      6'h00: begin
        ok = 1'b1;
        case (fn)
          6'h20: sel = 3'd2;
          6'h22: sel = 3'd6;
          6'h24: sel = 3'd0;
          6'h25: sel = 3'd1;
          6'h2A: sel = 3'd7;
          default: begin sel = 3'd2; ok = 1'b0; end
        endcase
        o = idle_out(); o.alu_src_a = 1'b1; o.alu_sel = sel;
        push_free(o);
        o = idle_out();
        if (ok) begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
        else    o.illegal = 1'b1;
        push_free(o);
      end
      6'h04: begin
        z = 1'($urandom);
        o = idle_out(); o.alu_src_a = 1'b1; o.alu_sel = 3'd6;
        o.pc_src = 2'b01; o.pc_en = z;
        push(1'($urandom), z, 1'b0, o);
      end
      6'h08: begin
        o = idle_out(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        push_free(o);
        o = idle_out(); o.reg_write = 1'b1;
        push_free(o);
      end
      6'h02: begin
        o = idle_out(); o.pc_src = 2'b10; o.pc_en = 1'b1;
        push_free(o);
      end
      default: begin
        o = idle_out(); o.illegal = 1'b1;
        push_free(o);
      end
    endcase
  endtask

  // Apply the queued cycles; garbage opcode/funct during fetch (IR not yet loaded).
  task automatic run_queue(input string name);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      alu_zero  = s.zero;
      if (s.fetch) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end else begin
        opcode = cur_op;
        funct  = cur_fn;
      end
      #1 check_out(name, obs, s.exp);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[14];
  out_t rst_vec;
  logic [5:0] ops[6];

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 2, 1, 0, 0, 1};
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, 6, 1, 0, 0, 1};
    vecs[2]  = '{6'h00, 6'h24, 1'b0, 4, 0, 1, 0, 0, 1};
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 4, 1, 1, 0, 0, 1};
    vecs[4]  = '{6'h00, 6'h2A, 1'b0, 4, 7, 1, 0, 0, 1};
    vecs[5]  = '{6'h00, 6'h21, 1'b0, 4, 2, 0, 0, 1, 1};
    vecs[6]  = '{6'h23, 6'h00, 1'b0, 5, 2, 1, 0, 0, 1};
    vecs[7]  = '{6'h2B, 6'h00, 1'b0, 4, 2, 0, 1, 0, 1};
    vecs[8]  = '{6'h08, 6'h00, 1'b0, 4, 2, 1, 0, 0, 1};
    vecs[9]  = '{6'h04, 6'h00, 1'b1, 3, 6, 0, 0, 0, 2};
    vecs[10] = '{6'h04, 6'h00, 1'b0, 3, 6, 0, 0, 0, 1};
    vecs[11] = '{6'h02, 6'h00, 1'b0, 3, 2, 0, 0, 0, 2};
    vecs[12] = '{6'h3F, 6'h00, 1'b0, 3, 2, 0, 0, 1, 1};
    vecs[13] = '{6'h05, 6'h2A, 1'b0, 3, 2, 0, 0, 1, 1};
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    rst_vec = fetch_out(1'b0);

    rst_n = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0;
    opcode = 6'h00; funct = 6'h20;

    // Held in reset: FETCH outputs with every load enable forced low.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'(i != 2);
      #1 check_out("reset_hold", obs, rst_vec);
    end
    rst_n = 1'b1;

    // Directed table, mem_ready tied high.
    foreach (vecs[k]) begin
      int rw, mw, il, pe, sel;
      rw = 0; mw = 0; il = 0; pe = 0; sel = -1;
      opcode = vecs[k].op; funct = vecs[k].fn;
      mem_ready = 1'b1; alu_zero = vecs[k].zero;
      for (int c = 0; c < vecs[k].cycles; c++) begin
        #1;
        rw += int'(reg_write); mw += int'(mem_write);
        il += int'(illegal);   pe += int'(pc_en);
        if (c == 2) sel = int'(alu_sel);
        @(negedge clk);
      end
      check_int($sformatf("v%0d_alu_sel", k), sel, vecs[k].sel_at2);
      check_int($sformatf("v%0d_reg_write", k), rw, vecs[k].n_rw);
      check_int($sformatf("v%0d_mem_write", k), mw, vecs[k].n_mw);
      check_int($sformatf("v%0d_illegal", k), il, vecs[k].n_ill);
      check_int($sformatf("v%0d_pc_en", k), pe, vecs[k].n_pcen);
      // Instruction must be over: back in FETCH exactly on schedule.
      #1 check_out($sformatf("v%0d_back_in_fetch", k), obs, fetch_out(1'b1));
    end
    @(negedge clk);
    // That last check consumed a fetch; finish the DECODE with a jump.
    opcode = 6'h02; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // lw with three stall cycles in MEMRD: 8 cycles total.
    build(6'h23, 6'h00, 0, 3);
    run_queue("lw_stall");
    // Fetch stalls too.
    build(6'h2B, 6'h00, 2, 1);
    run_queue("sw_stall");

    // Asynchronous reset in the middle of MEMWR.
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1 n_vec++;
    if (mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL memwr_before_reset: mem_write %b expected 1", mem_write);
    end
    #2 rst_n = 1'b0;
    #1 check_out("memwr_async_reset", obs, rst_vec);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check_out("memwr_reset_hold", obs, rst_vec);
    rst_n = 1'b1;
    @(negedge clk);
    // Reset was released with the FSM in FETCH; first edge took it to DECODE.
    opcode = 6'h02;
    #1 n_vec++;
    if (!(alu_src_b == 2'b11 && mem_read == 1'b0 && mem_write == 1'b0)) begin
      n_bad++;
      $display("FAIL post_reset_decode: alu_src_b %b mem_read %b expected 11/0",
               alu_src_b, mem_read);
    end
    @(negedge clk);
    @(negedge clk);

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(7, 0) == 0) ? 6'($urandom) : ops[$urandom_range(5, 0)];
      case ($urandom_range(5, 0))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2A;
        default: fn = 6'($urandom);
      endcase
      build(op, fn, $urandom_range(2, 0), $urandom_range(3, 0));
      run_queue("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
